// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode encoding, ALU and result-select
// codes, and the instruction field layout.
package decode_pkg;

   localparam int INSTR_W = 33;
   localparam int PCW     = 9;
   localparam int REG_AW  = 4;

   localparam int OPC_MSB = 32;
   localparam int OPC_LSB = 28;
   localparam int RD_MSB  = 27;
   localparam int RD_LSB  = 24;
   localparam int RS1_MSB = 23;
   localparam int RS1_LSB = 20;
   localparam int RS2_MSB = 19;
   localparam int RS2_LSB = 16;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [4:0] {
      OP_NOP  = 5'b00000,
      OP_ADD  = 5'b00001,
      OP_SUB  = 5'b00010,
      OP_AND  = 5'b00011,
      OP_OR   = 5'b00100,
      OP_XOR  = 5'b00101,
      OP_SLL  = 5'b00110,
      OP_SRL  = 5'b00111,
      OP_ADDI = 5'b01000,
      OP_LW   = 5'b01001,
      OP_SW   = 5'b01010,
      OP_BEQ  = 5'b01011,
      OP_BNE  = 5'b01100,
      OP_JAL  = 5'b01101
   } opcode_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC1 = 2'b10;

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port, r0 hardwired to zero.
module register_file #(
   parameter int NREGS = 16,
   parameter int DW    = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] addr1,
   input  logic [AW-1:0] addr2,
   output logic [DW-1:0] data1,
   output logic [DW-1:0] data2
);

   logic [DW-1:0] regs [NREGS];
   logic          wr_live;

   assign wr_live = wr_en && (wr_addr != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // r0 check comes first so a bypass can never leak a value onto r0
   always_comb begin
      data1 = regs[addr1];
      if (addr1 == '0)                         data1 = '0;
      else if (wr_live && (wr_addr == addr1))  data1 = wr_data;
   end

   always_comb begin
      data2 = regs[addr2];
      if (addr2 == '0)                         data2 = '0;
      else if (wr_live && (wr_addr == addr2))  data2 = wr_data;
   end

endmodule

// File: rtl/decode_cycle.sv
// Decode pipeline stage: register file read, control decode, immediate
// sign-extension and the decode/execute pipeline register with flush.
module decode_cycle
   import decode_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int DW    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] InstrD,
   input  logic [PCW-1:0]     PCD,
   input  logic [PCW-1:0]     PCPlus4D,
   input  logic               FlushE,
   input  logic               RegWriteW,
   input  logic [REG_AW-1:0]  RdW,
   input  logic [DW-1:0]      ResultW,
   output logic [DW-1:0]      RD1E,
   output logic [DW-1:0]      RD2E,
   output logic [DW-1:0]      ImmExtE,
   output logic [REG_AW-1:0]  Rs1E,
   output logic [REG_AW-1:0]  Rs2E,
   output logic [REG_AW-1:0]  RdE,
   output logic [PCW-1:0]     PCE,
   output logic [PCW-1:0]     PCPlus4E,
   output logic               RegWriteE,
   output logic               MemWriteE,
   output logic               ALUSrcE,
   output logic               BranchE,
   output logic               BranchNeE,
   output logic               JumpE,
   output logic [1:0]         ResultSrcE,
   output logic [3:0]         ALUControlE,
   output logic               IllegalE
);

   logic [4:0]        opc;
   logic [REG_AW-1:0] rd, rs1, rs2;
   logic [15:0]       imm16;
   logic [DW-1:0]     rd1, rd2, imm_ext;

   logic       reg_write, mem_write, alu_src, branch, branch_ne, jump, illegal;
   logic [1:0] result_src;
   logic [3:0] alu_control;

   assign opc     = InstrD[OPC_MSB:OPC_LSB];
   assign rd      = InstrD[RD_MSB:RD_LSB];
   assign rs1     = InstrD[RS1_MSB:RS1_LSB];
   assign rs2     = InstrD[RS2_MSB:RS2_LSB];
   assign imm16   = InstrD[IMM_MSB:IMM_LSB];
   assign imm_ext = {{(DW-16){imm16[15]}}, imm16};

   register_file #(.NREGS(NREGS), .DW(DW)) u_regs (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (RegWriteW),
      .wr_addr (RdW),
      .wr_data (ResultW),
      .addr1   (rs1),
      .addr2   (rs2),
      .data1   (rd1),
      .data2   (rd2)
   );

   always_comb begin
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      alu_src     = 1'b0;
      branch      = 1'b0;
      branch_ne   = 1'b0;
      jump        = 1'b0;
      illegal     = 1'b0;
      result_src  = RES_ALU;
      alu_control = ALU_ADD;
      case (opc)
         OP_NOP:  ;
         OP_ADD:  reg_write = 1'b1;
         OP_SUB:  begin reg_write = 1'b1; alu_control = ALU_SUB; end
         OP_AND:  begin reg_write = 1'b1; alu_control = ALU_AND; end
         OP_OR:   begin reg_write = 1'b1; alu_control = ALU_OR;  end
         OP_XOR:  begin reg_write = 1'b1; alu_control = ALU_XOR; end
         OP_SLL:  begin reg_write = 1'b1; alu_control = ALU_SLL; end
         OP_SRL:  begin reg_write = 1'b1; alu_control = ALU_SRL; end
         OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; end
         OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; end
         OP_SW:   begin mem_write = 1'b1; alu_src = 1'b1; end
         OP_BEQ:  begin branch = 1'b1; alu_control = ALU_SUB; end
         OP_BNE:  begin branch = 1'b1; branch_ne = 1'b1; alu_control = ALU_SUB; end
         OP_JAL:  begin jump = 1'b1; reg_write = 1'b1; result_src = RES_PC1; end
         default: illegal = 1'b1;
      endcase
      if (rd == '0) reg_write = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst || FlushE) begin
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         BranchE     <= 1'b0;
         BranchNeE   <= 1'b0;
         JumpE       <= 1'b0;
         ResultSrcE  <= '0;
         ALUControlE <= '0;
         IllegalE    <= 1'b0;
      end else begin
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= imm_ext;
         Rs1E        <= rs1;
         Rs2E        <= rs2;
         RdE         <= rd;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         RegWriteE   <= reg_write;
         MemWriteE   <= mem_write;
         ALUSrcE     <= alu_src;
         BranchE     <= branch;
         BranchNeE   <= branch_ne;
         JumpE       <= jump;
         ResultSrcE  <= result_src;
         ALUControlE <= alu_control;
         IllegalE    <= illegal;
      end
   end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second pipeline stage of the processor core: consumes the fetch/decode pipeline register (`InstrD`, `PCD`, `PCPlus4D`) and produces the decode/execute pipeline register. It contains the 16×32 register file, which is written by writeback. It decodes the 33-bit instruction into control signals, sign-extends the immediate, and inserts a bubble on a taken branch or jump (`FlushE`, driven from `PCSrcE`).

## Interface
- `NREGS`, 16: number of architectural registers; `r0` is hardwired to zero.
- `DW`, 32: data width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `InstrD` in 33: instruction from fetch.
- `PCD`, `PCPlus4D` in 9 each: word-addressed PC and PC+1 from fetch.
- `FlushE` in 1: replace the next E register contents with a bubble.
- `RegWriteW` in 1, `RdW` in 4, `ResultW` in 32: writeback write port.
- `RD1E`, `RD2E` out 32: operand values.
- `ImmExtE` out 32: sign-extended immediate.
- `Rs1E`, `Rs2E`, `RdE` out 4: register indices, for the hazard unit.
- `PCE`, `PCPlus4E` out 9: PC and PC+1 passed to execute.
- `RegWriteE`, `MemWriteE`, `ALUSrcE`, `BranchE`, `BranchNeE`, `JumpE` out 1 each: control signals.
- `ResultSrcE` out 2: result select; 00 ALU, 01 memory, 10 PC+1.
- `ALUControlE` out 4: ALU operation.
- `IllegalE` out 1: the E-stage instruction had an undefined opcode.

## Operation
- Instruction fields:
  - opcode = `InstrD[32:28]`
  - rd = `[27:24]`
  - rs1 = `[23:20]`
  - rs2 = `[19:16]`
  - imm16 = `[15:0]`
- Opcodes (any signal not listed is 0; ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110):
  - 00000 NOP: all control signals 0.
  - 00001–00111 ADD/SUB/AND/OR/XOR/SLL/SRL: RegWrite=1, ALUSrc=0, ALU code as listed.
  - 01000 ADDI: RegWrite=1, ALUSrc=1, ADD.
  - 01001 LW: RegWrite=1, ALUSrc=1, ResultSrc=01, ADD.
  - 01010 SW: MemWrite=1, ALUSrc=1, ADD, RegWrite=0.
  - 01011 BEQ: Branch=1, SUB.
  - 01100 BNE: Branch=1, BranchNe=1, SUB.
  - 01101 JAL: Jump=1, RegWrite=1, ResultSrc=10.
- Undefined opcodes (01110–11111): all control signals 0, `IllegalE`=1, data fields pass through.
- Any instruction with rd=0 forces RegWriteE=0.
- `ImmExtE` = imm16 sign-extended to 32 bits for every opcode. Execute truncates it to 9 bits for branch targets.
- Register file:
  - Two combinational read ports indexed by rs1 and rs2.
  - One synchronous write port: writes `ResultW` to `RdW` on the clock edge when `RegWriteW`=1 and `RdW`≠0.
  - Reads of `r0` return 0.
- Write-through bypass: if `RegWriteW`=1, `RdW`≠0 and `RdW` equals rs1 (or rs2), the corresponding read returns `ResultW` in the same cycle.
- Flush: when `FlushE`=1 at the clock edge, every E output register loads 0. This is a NOP bubble, with `IllegalE`=0. The register-file write still occurs in that cycle.

## Timing
- Latency from `InstrD` to the E outputs is 1 cycle. There is no stall input; the block advances every cycle.
- Reset (`rst`=0, asynchronous):
  - All E outputs are 0 immediately, including `PCE` and `PCPlus4E`.
  - All 16 registers clear to 0.
  - Writeback writes are ignored while reset is held.
  - Behaviour is the same if reset asserts in the middle of a program.
- Priority at the clock edge: reset > `FlushE` > normal decode.
- A write and a read of the same register in the same cycle use the bypassed value, so the new value reaches `RD1E`/`RD2E` one cycle later.
- `RegWriteW` with `RdW`=0 has no effect, and reads of `r0` still return 0.

## Structure
- Package `decode_pkg` holds:
  - the opcode enum (5 bits),
  - ALU control constants (4 bits),
  - ResultSrc constants,
  - field bit-position localparams,
  - the instruction width (33).
- Sub-module `register_file`: NREGS×DW storage, two read ports, one write port, with bypass and asynchronous clear inside.
- The control decoder is a combinational `always_comb` block in `decode_cycle`.
- The E pipeline register lives in `decode_cycle`.

## Test plan
- Reset: hold `rst`=0 with arbitrary `InstrD` → all E outputs 0. After release, reading `r1` and `r15` returns 0.
- Write and read back: write `r3`=0x0000_00AA. Next cycle, decode ADD r5,r3,r0 → `RD1E`=0xAA, `RD2E`=0, `RegWriteE`=1, `ALUControlE`=0000, `RdE`=5.
- Bypass: same cycle `RegWriteW`=1, `RdW`=4, `ResultW`=0x1234, `InstrD`=SUB r6,r4,r4 → next cycle `RD1E`=`RD2E`=0x1234.
- Immediate and control:
  - LW r2,-3(r1) → `ImmExtE`=0xFFFF_FFFD, `ResultSrcE`=01, `ALUSrcE`=1.
  - JAL r7 with `PCD`=0x10, `PCPlus4D`=0x11 → `JumpE`=1, `ResultSrcE`=10, `PCPlus4E`=0x11.
- Flush: `FlushE`=1 with ADDI r1,r1,5 in D → all E outputs 0. Simultaneous `RegWriteW` to `r2`=7 still lands; a later read of `r2` returns 7.
- Illegal and r0 guards:
  - Opcode 11111 → `IllegalE`=1, all control signals 0.
  - ADD r0,r1,r1 → `RegWriteE`=0.
  - Write to `r0` with `ResultW`=0xFFFF_FFFF → later read of `r0` returns 0.
